// File: rtl/reciprocal_nr_if.sv
// Operand/result handshake bundle for reciprocal_nr: valid/ready in, valid/ready out.
// The master side produces operands and consumes results; the slave side is the divider.
interface reciprocal_nr_if;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_sat,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_sat,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/reciprocal_nr.sv
// Sequential signed Q12.12 reciprocal by Newton-Raphson on a single shared 24x24 multiplier.
// Optional RECIP_POW2_FAST_EN: exact 2.0 seed and skipped iterations when |x| is a power of two.
module reciprocal_nr #(
  parameter int unsigned ITERS = 3
) (
  input  logic           clk,
  input  logic           reset,
  reciprocal_nr_if.slave bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StNorm   = 3'd1;
  localparam logic [2:0] StSeed   = 3'd2;
  localparam logic [2:0] StMulE   = 3'd3;
  localparam logic [2:0] StMulX   = 3'd4;
  localparam logic [2:0] StDenorm = 3'd5;
  localparam logic [2:0] StDone   = 3'd6;

  localparam logic [23:0] SeedC0   = 24'hB4B4B5;  // 48/17 in Q2.22
  localparam logic [23:0] SeedC1   = 24'h787878;  // 32/17 in Q2.22
  localparam logic [23:0] Two      = 24'h800000;  // 2.0 in Q2.22, also 0.5 in Q0.24
  localparam logic [23:0] SatMag   = 24'h7FFFFF;
  localparam logic [23:0] SatNeg   = 24'h800000;
  localparam logic [2:0]  LastIter = 3'(ITERS - 1);

  logic [2:0]  state_q, state_d;
  logic        sign_q, sign_d;
  logic [23:0] mag_q, mag_d;      // |x| in IDLE/NORM, normalised d afterwards
  logic [4:0]  shift_q, shift_d;
  logic [23:0] x_q, x_d;
  logic [23:0] e_q, e_d;
  logic [2:0]  iter_q, iter_d;
  logic [23:0] out_data_q, out_data_d;
  logic        out_sat_q, out_sat_d;

  logic [4:0]  lzc_n;
  logic [23:0] mul_a, mul_b;
  logic [47:0] prod;
  logic [26:0] x_ext, r_mag;
  logic        r_sat;
  logic        unused_prod;

  always_comb begin
    lzc_n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (mag_q[i]) lzc_n = 5'(23 - i);
    end
  end

  // Operand mux for the one shared multiplier.
  always_comb begin
    mul_a = mag_q;
    mul_b = x_q;
    case (state_q)
      StSeed: begin
        mul_a = SeedC1;
        mul_b = {2'b00, mag_q[23:2]};
      end
      StMulX: begin
        mul_a = x_q;
        mul_b = Two - e_q;
      end
      default: ;
    endcase
  end

  assign prod        = {24'd0, mul_a} * {24'd0, mul_b};
  assign unused_prod = ^prod[21:0];

  assign x_ext = {3'b000, x_q};

  always_comb begin
    if (shift_q <= 5'd22) begin
      r_mag = x_ext >> (5'd22 - shift_q);
    end else begin
      r_mag = x_ext << (shift_q - 5'd22);
    end
    r_sat = (shift_q == 5'd24) || (r_mag > {3'b000, SatMag});
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    shift_d    = shift_q;
    x_d        = x_q;
    e_d        = e_q;
    iter_d     = iter_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sign_d  = bus.in_data[23];
          mag_d   = bus.in_data[23] ? (~bus.in_data + 24'd1) : bus.in_data;
          state_d = StNorm;
        end
      end
      StNorm: begin
        shift_d = lzc_n;
        mag_d   = mag_q << lzc_n;
        state_d = (lzc_n == 5'd24) ? StDenorm : StSeed;
      end
      StSeed: begin
        x_d     = SeedC0 - prod[45:22];
        iter_d  = 3'd0;
        state_d = StMulE;
`ifdef RECIP_POW2_FAST_EN
        if (mag_q == Two) begin
          x_d     = Two;
          state_d = StDenorm;
        end
`endif
      end
      StMulE: begin
        e_d     = prod[47:24];
        state_d = StMulX;
      end
      StMulX: begin
        x_d = prod[45:22];
        if (iter_q == LastIter) begin
          state_d = StDenorm;
        end else begin
          iter_d  = iter_q + 3'd1;
          state_d = StMulE;
        end
      end
      StDenorm: begin
        out_sat_d = r_sat;
        if (r_sat) begin
          out_data_d = sign_q ? SatNeg : SatMag;
        end else begin
          out_data_d = sign_q ? (~r_mag[23:0] + 24'd1) : r_mag[23:0];
        end
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      shift_q    <= '0;
      x_q        <= '0;
      e_q        <= '0;
      iter_q     <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      shift_q    <= shift_d;
      x_q        <= x_d;
      e_q        <= e_d;
      iter_q     <= iter_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule
